// File: rtl/dns_amp_detector.sv
// dns_amp_detector: counts DNS queries from ports 0-3 per cnt_time window and
// runs a hysteresis FSM on the response/query ratio to flag DNS amplification.
// Optional feature: define DNS_AMP_IRQ_EN to add the alarm_irq output, a
// one-cycle pulse on each entry into ALARM.
module dns_amp_detector #(
    parameter logic [27:0] WINDOW_TICK   = 28'd160000000,
    parameter int unsigned RATIO_SHIFT   = 3,
    parameter logic [31:0] SUIT_MIN      = 32'd100,
    parameter int unsigned ALARM_WINDOWS = 3,
    parameter int unsigned CLEAR_WINDOWS = 2
) (
    input  logic        asclk,
    input  logic        aresetn,
    input  logic [27:0] cnt_time,
    input  logic        pkt_vld_3rd,
    input  logic [2:0]  proc_port_3rd,
    input  logic [15:0] tp_dest,
    input  logic [31:0] num_total_dns_response,
    input  logic [31:0] num_suitable_dns_response,
    output logic [31:0] num_dns_query,
    output logic        dns_alarm,
    output logic [15:0] alarm_count
`ifdef DNS_AMP_IRQ_EN
    ,
    output logic        alarm_irq
`endif
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    localparam logic [3:0] ALARM_N = 4'(ALARM_WINDOWS);
    localparam logic [3:0] CLEAR_N = 4'(CLEAR_WINDOWS);

    logic [31:0] query_tmp;
    logic        eval_pulse;
    logic        tick;
    logic        query_hit;
    logic [39:0] total_ext;
    logic [39:0] query_scaled;
    logic        susp;

    state_t      state;
    state_t      next_state;
    logic [3:0]  streak;
    logic [3:0]  next_streak;
    logic [3:0]  streak_inc;
    logic        enter_alarm;

    assign tick      = (cnt_time == WINDOW_TICK);
    assign query_hit = pkt_vld_3rd && (proc_port_3rd <= 3'd3) && (tp_dest == 16'd53);

    // 40-bit compare: the shifted query count can never overflow
    assign total_ext    = {8'b0, num_total_dns_response};
    assign query_scaled = {8'b0, num_dns_query} << RATIO_SHIFT;
    assign susp         = (num_suitable_dns_response >= SUIT_MIN) && (total_ext > query_scaled);

    assign streak_inc = streak + 4'd1;

    // Query counting and window latch; the tick takes priority over a same-cycle query
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            query_tmp     <= '0;
            num_dns_query <= '0;
            eval_pulse    <= 1'b0;
        end else if (tick) begin
            num_dns_query <= query_tmp;
            query_tmp     <= '0;
            eval_pulse    <= 1'b1;
        end else begin
            eval_pulse <= 1'b0;
            if (query_hit && (query_tmp != '1)) begin
                query_tmp <= query_tmp + 32'd1;
            end
        end
    end

    // FSM state and streak register
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            state  <= ST_NORMAL;
            streak <= '0;
        end else begin
            state  <= next_state;
            streak <= next_streak;
        end
    end

    // Next-state logic; advances only on eval_pulse. Streak is cleared on
    // entering ALARM so it can be reused as the clean-window counter.
    always_comb begin
        next_state  = state;
        next_streak = streak;
        if (eval_pulse) begin
            case (state)
                ST_NORMAL: begin
                    if (susp) begin
                        if (ALARM_N == 4'd1) begin
                            next_state  = ST_ALARM;
                            next_streak = '0;
                        end else begin
                            next_state  = ST_SUSPECT;
                            next_streak = 4'd1;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (susp) begin
                        if (streak_inc == ALARM_N) begin
                            next_state  = ST_ALARM;
                            next_streak = '0;
                        end else begin
                            next_streak = streak_inc;
                        end
                    end else begin
                        next_state  = ST_NORMAL;
                        next_streak = '0;
                    end
                end
                ST_ALARM: begin
                    if (susp) begin
                        next_streak = '0;
                    end else if (streak_inc == CLEAR_N) begin
                        next_state  = ST_NORMAL;
                        next_streak = '0;
                    end else begin
                        next_streak = streak_inc;
                    end
                end
                default: begin
                    next_state  = ST_NORMAL;
                    next_streak = '0;
                end
            endcase
        end
    end

    assign enter_alarm = (next_state == ST_ALARM) && (state != ST_ALARM);

    // Registered alarm outputs, updated in the cycle after the causing eval_pulse
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            dns_alarm   <= 1'b0;
            alarm_count <= '0;
        end else begin
            dns_alarm <= (next_state == ST_ALARM);
            if (enter_alarm && (alarm_count != '1)) begin
                alarm_count <= alarm_count + 16'd1;
            end
        end
    end

`ifdef DNS_AMP_IRQ_EN
    // Interrupt pulse aligned with the rising edge of dns_alarm
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            alarm_irq <= 1'b0;
        end else begin
            alarm_irq <= enter_alarm;
        end
    end
`endif

endmodule

// File: tb/tb_dns_amp_detector.sv
// tb_dns_amp_detector: window-level stimulus with a counting reference model.
module tb_dns_amp_detector;

    localparam int AW = 3;
    localparam int CW = 2;

    logic        asclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [27:0] cnt_time = '0;
    logic        pkt_vld_3rd = 1'b0;
    logic [2:0]  proc_port_3rd = '0;
    logic [15:0] tp_dest = '0;
    logic [31:0] num_total_dns_response = '0;
    logic [31:0] num_suitable_dns_response = '0;
    logic [31:0] num_dns_query;
    logic        dns_alarm;
    logic [15:0] alarm_count;
`ifdef DNS_AMP_IRQ_EN
    logic        alarm_irq;
`endif

    dns_amp_detector #(
        .WINDOW_TICK(28'd100)
    ) dut (
        .asclk                    (asclk),
        .aresetn                  (aresetn),
        .cnt_time                 (cnt_time),
        .pkt_vld_3rd              (pkt_vld_3rd),
        .proc_port_3rd            (proc_port_3rd),
        .tp_dest                  (tp_dest),
        .num_total_dns_response   (num_total_dns_response),
        .num_suitable_dns_response(num_suitable_dns_response),
        .num_dns_query            (num_dns_query),
        .dns_alarm                (dns_alarm),
        .alarm_count              (alarm_count)
`ifdef DNS_AMP_IRQ_EN
        ,
        .alarm_irq                (alarm_irq)
`endif
    );

    always #5 asclk = ~asclk;

    int checks = 0;
    int errors = 0;

    // Reference model state: counts of consecutive suspicious/clean windows
    int unsigned m_qcnt;
    longint      m_nq;
    bit          m_alarm;
    bit          m_entered;
    int          m_sus_run;
    int          m_clean_run;
    int unsigned m_alarm_cnt;
    bit          have_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_qcnt      = 0;
        m_nq        = 0;
        m_alarm     = 0;
        m_entered   = 0;
        m_sus_run   = 0;
        m_clean_run = 0;
        m_alarm_cnt = 0;
    endfunction

    // One evaluation: a window is suspicious when enough large responses were
    // seen and responses exceed eight times the queries.
    function automatic void model_eval();
        bit susp;
        susp = (longint'(num_suitable_dns_response) >= 100) &&
               (longint'(num_total_dns_response) > m_nq * 8);
        m_entered = 0;
        if (!m_alarm) begin
            m_sus_run = susp ? m_sus_run + 1 : 0;
            if (m_sus_run >= AW) begin
                m_alarm     = 1;
                m_entered   = 1;
                m_alarm_cnt++;
                m_clean_run = 0;
            end
        end else begin
            m_clean_run = susp ? 0 : m_clean_run + 1;
            if (m_clean_run >= CW) begin
                m_alarm   = 0;
                m_sus_run = 0;
            end
        end
    endfunction

    // kind: 0 idle, 1 qualifying, 2 port>3, 3 wrong tp_dest, 4 no strobe
    task automatic drive_pkt(input int kind);
        pkt_vld_3rd   = (kind != 0) && (kind != 4);
        proc_port_3rd = 3'($urandom_range(0, 3));
        tp_dest       = 16'd53;
        case (kind)
            2: proc_port_3rd = 3'($urandom_range(4, 7));
            3: tp_dest = ($urandom_range(0, 1) == 0) ? 16'd80 : 16'd54;
            default: ;
        endcase
    endtask

    function automatic int noise_kind();
        int r;
        r = int'($urandom_range(0, 3));
        return (r == 0) ? 0 : r + 1;
    endfunction

    // want<0: random query count; tot/suit<0: random near the ratio boundary;
    // rst_at>=0: pulse reset for two cycles at that window position.
    task automatic run_window(input int want, input longint tot_in, input longint suit_in,
                              input int rst_at);
        int     kind;
        longint q8;
        for (int c = 0; c <= 100; c++) begin
            @(negedge asclk);
            cnt_time = 28'(c);
            if (have_prev && c == 0) begin
                check("num_dns_query", num_dns_query, m_nq);
                model_eval();
            end
            if (have_prev && c == 1) begin
                check("dns_alarm", dns_alarm, m_alarm);
                check("alarm_count", alarm_count, m_alarm_cnt);
`ifdef DNS_AMP_IRQ_EN
                check("alarm_irq", alarm_irq, m_entered);
`endif
            end
`ifdef DNS_AMP_IRQ_EN
            if (have_prev && c == 2) check("alarm_irq_one_cycle", alarm_irq, 0);
`endif
            if (rst_at >= 0 && c == rst_at + 1) begin
                check("rst_num_dns_query", num_dns_query, 0);
                check("rst_dns_alarm", dns_alarm, 0);
                check("rst_alarm_count", alarm_count, 0);
            end
            if (rst_at >= 0 && c == rst_at) aresetn = 1'b0;
            if (rst_at >= 0 && c == rst_at + 2) aresetn = 1'b1;
            if (!aresetn) model_reset();

            if (c < 2) kind = 0;
            else if (c == 100) kind = 1;
            else if (want >= 0) kind = (c - 2 < want) ? 1 : noise_kind();
            else kind = ($urandom_range(0, 2) == 0) ? 1 : noise_kind();
            drive_pkt(kind);
            if (kind == 1 && aresetn && c != 100) m_qcnt++;

            if (c == 99) begin
                q8 = longint'(m_qcnt) * 8;
                if (tot_in >= 0) num_total_dns_response = 32'(tot_in);
                else case ($urandom_range(0, 3))
                    0: num_total_dns_response = 32'((q8 > 0) ? q8 - 1 : 0);
                    1: num_total_dns_response = 32'(q8);
                    2: num_total_dns_response = 32'(q8 + 1);
                    default: num_total_dns_response = $urandom;
                endcase
                if (suit_in >= 0) num_suitable_dns_response = 32'(suit_in);
                else case ($urandom_range(0, 3))
                    0: num_suitable_dns_response = 32'd99;
                    1: num_suitable_dns_response = 32'd100;
                    2: num_suitable_dns_response = 32'($urandom_range(0, 300));
                    default: num_suitable_dns_response = 32'hFFFF_FFFF;
                endcase
            end
            if (c == 100 && aresetn) begin
                m_nq      = longint'(m_qcnt);
                m_qcnt    = 0;
                have_prev = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        have_prev = 0;
        aresetn   = 1'b0;
        repeat (3) @(negedge asclk);
        check("reset_num_dns_query", num_dns_query, 0);
        check("reset_dns_alarm", dns_alarm, 0);
        check("reset_alarm_count", alarm_count, 0);
`ifdef DNS_AMP_IRQ_EN
        check("reset_alarm_irq", alarm_irq, 0);
`endif
        aresetn = 1'b1;

        // 40 qualifying queries amid non-qualifying noise; tick-cycle strobe dropped
        run_window(40, 0, 0, -1);
        run_window(0, 0, 0, -1);
        // three suspicious windows raise the alarm
        repeat (3) run_window(10, 1000, 200, -1);
        // clean, suspicious, then two clean windows
        run_window(10, 0, 0, -1);
        run_window(10, 1000, 200, -1);
        run_window(10, 0, 0, -1);
        run_window(10, 0, 0, -1);
        // boundaries: too few large responses, and total equal to queries<<3
        repeat (3) run_window(10, 1000, 99, -1);
        repeat (3) run_window(10, 80, 200, -1);
        run_window(10, 81, 100, -1);
        run_window(10, 0, 0, -1);
        // reset while SUSPECT with two suspicious windows behind it
        run_window(10, 1000, 200, -1);
        run_window(10, 1000, 200, -1);
        run_window(10, 1000, 200, 60);
        repeat (3) run_window(5, 1000, 200, -1);
        run_window(5, 0, 0, -1);
        run_window(5, 0, 0, -1);
        // randomized windows around the ratio and SUIT_MIN boundaries
        repeat (40) run_window(-1, -1, -1, -1);
        run_window(0, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
